// File: rtl/fc_mac_pkg.sv
// Shared limits, pipeline tag type and saturation bounds for the fc_mac_pipe MAC slice.
package fc_mac_pkg;

    localparam int MIN_DIN_WIDTH = 2;
    localparam int MAX_DIN_WIDTH = 32;
    localparam int MIN_STAGE     = 1;
    localparam int MAX_STAGE     = 4;
    localparam int MAX_ACC_WIDTH = 128;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
        logic is_signed;
    } mac_tag_t;

    // Bounds are built MAX_ACC_WIDTH wide; callers size-cast down to their ACC_WIDTH.
    function automatic logic [MAX_ACC_WIDTH-1:0] sat_max(input int acc_width, input logic sgn);
        logic [MAX_ACC_WIDTH-1:0] bound;
        bound = '0;
        for (int i = 0; i < MAX_ACC_WIDTH; i++) begin
            if (i < acc_width - (sgn ? 1 : 0)) bound[i] = 1'b1;
        end
        return bound;
    endfunction

    function automatic logic [MAX_ACC_WIDTH-1:0] sat_min(input int acc_width, input logic sgn);
        logic [MAX_ACC_WIDTH-1:0] bound;
        bound = '0;
        for (int i = 0; i < MAX_ACC_WIDTH; i++) begin
            if (sgn && (i == acc_width - 1)) bound[i] = 1'b1;
        end
        return bound;
    endfunction

endpackage

// File: rtl/fc_mac_mul_pipe.sv
// Operand extension, multiply and NUM_STAGE-deep product/tag register chain.
// The whole chain shares one advance enable so a stall freezes it as a unit.
module fc_mac_mul_pipe
    import fc_mac_pkg::*;
#(
    parameter int DIN0_WIDTH = 32,
    parameter int DIN1_WIDTH = 32,
    parameter int NUM_STAGE  = 2,
    parameter int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH + 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         advance,
    input  mac_tag_t                     tag_in,
    input  logic [DIN0_WIDTH-1:0]        din0,
    input  logic [DIN1_WIDTH-1:0]        din1,
    output mac_tag_t                     tag_out,
    output logic signed [PROD_WIDTH-1:0] prod
);

    logic signed [DIN0_WIDTH:0]     op0;
    logic signed [DIN1_WIDTH:0]     op1;
    logic signed [PROD_WIDTH-1:0]   product;
    mac_tag_t                       tag_q  [NUM_STAGE];
    logic signed [PROD_WIDTH-1:0]   prod_q [NUM_STAGE];

    // One extra bit per operand lets a single signed multiplier serve both modes.
    assign op0     = {tag_in.is_signed & din0[DIN0_WIDTH-1], din0};
    assign op1     = {tag_in.is_signed & din1[DIN1_WIDTH-1], din1};
    assign product = PROD_WIDTH'(op0) * PROD_WIDTH'(op1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                tag_q[i]  <= '0;
                prod_q[i] <= '0;
            end
        end else if (advance) begin
            tag_q[0]  <= tag_in;
            prod_q[0] <= product;
            for (int i = 1; i < NUM_STAGE; i++) begin
                tag_q[i]  <= tag_q[i-1];
                prod_q[i] <= prod_q[i-1];
            end
        end
    end

    assign tag_out = tag_q[NUM_STAGE-1];
    assign prod    = prod_q[NUM_STAGE-1];

endmodule

// File: rtl/fc_mac_pipe.sv
// Pipelined multiply-accumulate for FC layers with valid/ready flow control.
// Optional clamping on overflow is built when FC_MAC_SATURATE_EN is defined.
module fc_mac_pipe
    import fc_mac_pkg::*;
#(
    parameter int DIN0_WIDTH = 32,
    parameter int DIN1_WIDTH = 32,
    parameter int NUM_STAGE  = 2,
    parameter int ACC_WIDTH  = 72
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  is_signed,
    input  logic                  first,
    input  logic                  last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  dout,
    output logic                  ovf
);

    localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH + 2;
    localparam int MSB        = ACC_WIDTH - 1;

    logic                         stall;
    logic                         advance;
    mac_tag_t                     in_tag;
    mac_tag_t                     tail_tag;
    logic signed [PROD_WIDTH-1:0] tail_prod;
    logic [ACC_WIDTH-1:0]         prod_acc;
    logic [ACC_WIDTH:0]           sum_wide;
    logic                         add_ovf;
    logic [ACC_WIDTH-1:0]         acc_q;
    logic [ACC_WIDTH-1:0]         acc_d;
    logic                         ovf_q;
    logic                         ovf_d;
    logic                         done_q;

    // A held result freezes the whole pipe, even when nothing in it is a last beat.
    assign stall    = !ce | (out_valid & !out_ready);
    assign advance  = !stall;
    assign in_ready = !reset & !stall;

    assign in_tag = '{valid: in_valid, first: first, last: last, is_signed: is_signed};

    fc_mac_mul_pipe #(
        .DIN0_WIDTH (DIN0_WIDTH),
        .DIN1_WIDTH (DIN1_WIDTH),
        .NUM_STAGE  (NUM_STAGE),
        .PROD_WIDTH (PROD_WIDTH)
    ) u_mul_pipe (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .tag_in  (in_tag),
        .din0    (din0),
        .din1    (din1),
        .tag_out (tail_tag),
        .prod    (tail_prod)
    );

    // The product always fits in DIN0+DIN1+1 bits, so resizing to ACC_WIDTH is lossless.
    assign prod_acc = ACC_WIDTH'(tail_prod);
    assign sum_wide = {1'b0, acc_q} + {1'b0, prod_acc};

    always_comb begin
        add_ovf = tail_tag.is_signed
                ? ((acc_q[MSB] == prod_acc[MSB]) && (sum_wide[MSB] != acc_q[MSB]))
                : sum_wide[ACC_WIDTH];
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (tail_tag.valid) begin
            if (tail_tag.first) begin
                acc_d = prod_acc;
                ovf_d = 1'b0;
            end else begin
`ifdef FC_MAC_SATURATE_EN
                if (ovf_q) begin
                    acc_d = acc_q;
                end else if (add_ovf) begin
                    acc_d = (tail_tag.is_signed && acc_q[MSB])
                          ? ACC_WIDTH'(sat_min(ACC_WIDTH, 1'b1))
                          : ACC_WIDTH'(sat_max(ACC_WIDTH, tail_tag.is_signed));
                end else begin
                    acc_d = sum_wide[ACC_WIDTH-1:0];
                end
`else
                acc_d = sum_wide[ACC_WIDTH-1:0];
`endif
                ovf_d = ovf_q | add_ovf;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (advance) begin
            acc_q  <= acc_d;
            ovf_q  <= ovf_d;
            done_q <= tail_tag.valid & tail_tag.last;
        end
    end

    // While advancing, any held result is being taken, so out_valid simply follows done_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            dout      <= '0;
            ovf       <= 1'b0;
        end else if (advance) begin
            out_valid <= done_q;
            if (done_q) begin
                dout <= acc_q;
                ovf  <= ovf_q;
            end
        end
    end

endmodule
